// File: rtl/eight_bit_mul_seq.sv
// Sequential 8x8 shift-add multiplier: one multiplier bit per cycle, 8-cycle latency.
// Define EIGHT_BIT_MUL_SIGNED_EN for two's-complement operands; default is unsigned.
module eight_bit_mul_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    localparam int unsigned OP_W   = 8;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned ACC_W  = 17;
    localparam int unsigned CNT_W  = 3;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OP_W - 1);

    logic [0:0]        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [PROD_W-1:0] mcand, mcand_nxt;
    logic [OP_W-1:0]   mplier, mplier_nxt;
    logic [ACC_W-1:0]  acc, acc_nxt;
    logic              busy_nxt, done_nxt;
    logic [PROD_W-1:0] product_nxt;

    logic [PROD_W-1:0] ext_a;
    logic              sub_step;
    logic [ACC_W-1:0]  addend;
    logic [ACC_W-1:0]  acc_step;

`ifdef EIGHT_BIT_MUL_SIGNED_EN
    // Multiplier MSB carries weight -2^7, so its partial product is subtracted.
    assign ext_a    = {{OP_W{a[OP_W-1]}}, a};
    assign sub_step = (cnt == LAST_CNT);
`else
    assign ext_a    = {{OP_W{1'b0}}, a};
    assign sub_step = 1'b0;
`endif

    assign addend   = mplier[0] ? {1'b0, mcand} : '0;
    assign acc_step = sub_step ? (acc - addend) : (acc + addend);

    // Next-state and output logic
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        mcand_nxt   = mcand;
        mplier_nxt  = mplier;
        acc_nxt     = acc;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        product_nxt = product;

        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (start) begin
                    state_nxt  = RUN;
                    cnt_nxt    = '0;
                    mcand_nxt  = ext_a;
                    mplier_nxt = b;
                    acc_nxt    = '0;
                    busy_nxt   = 1'b1;
                end
            end
            RUN: begin
                acc_nxt    = acc_step;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                cnt_nxt    = cnt + CNT_W'(1);
                if (cnt == LAST_CNT) begin
                    state_nxt   = IDLE;
                    busy_nxt    = 1'b0;
                    done_nxt    = 1'b1;
                    product_nxt = acc_step[PROD_W-1:0];
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            mcand   <= mcand_nxt;
            mplier  <= mplier_nxt;
            acc     <= acc_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            product <= product_nxt;
        end
    end

endmodule

// File: tb/tb_eight_bit_mul_seq.sv
// Scoreboard bench for eight_bit_mul_seq: stimulus pushes expected products,
// a negedge monitor pops and compares on each done pulse.
module tb_eight_bit_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int unsigned n_cmp;
    int unsigned n_err;
    logic [15:0] exp_q[$];
    logic [15:0] prod_model;

`ifdef EIGHT_BIT_MUL_SIGNED_EN
    localparam logic [15:0] EXP_FF_FF = 16'h0001;
    localparam logic [15:0] EXP_80_7F = 16'hC080;
    localparam logic [15:0] EXP_FF_01 = 16'hFFFF;
`else
    localparam logic [15:0] EXP_FF_FF = 16'hFE01;
    localparam logic [15:0] EXP_80_7F = 16'h3F80;
    localparam logic [15:0] EXP_FF_01 = 16'h00FF;
`endif

    eight_bit_mul_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One start pulse; checks handshake timing, scrambles operands after acceptance.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic [15:0] exp);
        a     = va;
        b     = vb;
        start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~va;
        b     = ~vb;
        check("busy_after_accept", 16'(busy), 16'h1);
        repeat (7) @(posedge clk);
        #1;
        check("done_early", 16'(done), 16'h0);
        check("busy_running", 16'(busy), 16'h1);
        @(posedge clk);
        #1;
        check("done_at_k8", 16'(done), 16'h1);
        check("busy_at_k8", 16'(busy), 16'h0);
        @(posedge clk);
        #1;
        check("done_clear_k9", 16'(done), 16'h0);
    endtask

    // Monitor: product must change only on done, and match the scoreboard.
    initial begin
        prod_model = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prod_model = '0;
                check("rst_product", product, 16'h0000);
                check("rst_done", 16'(done), 16'h0);
                check("rst_busy", 16'(busy), 16'h0);
            end else if (done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: product %h, no result expected at %0t", product, $time);
                end else begin
                    prod_model = exp_q.pop_front();
                    check("product", product, prod_model);
                end
            end else begin
                check("product_hold", product, prod_model);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #2;
        check("reset_product_async", product, 16'h0000);
        check("reset_busy_async", 16'(busy), 16'h0);
        check("reset_done_async", 16'(done), 16'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_op(8'h0F, 8'h0A, 16'h0096);
        run_op(8'hFF, 8'hFF, EXP_FF_FF);
        run_op(8'h80, 8'h7F, EXP_80_7F);
        run_op(8'h80, 8'h80, 16'h4000);
        run_op(8'h00, 8'hFF, 16'h0000);
        run_op(8'hFF, 8'h01, EXP_FF_01);
        repeat (3) @(posedge clk);
        #1;

        // Second start while busy must be ignored.
        a     = 8'h03;
        b     = 8'h05;
        start = 1'b1;
        exp_q.push_back(16'h000F);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a     = 8'h07;
        b     = 8'h07;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("ign_done_early", 16'(done), 16'h0);
        @(posedge clk);
        #1;
        check("ign_done_k8", 16'(done), 16'h1);
        check("ign_busy_k8", 16'(busy), 16'h0);
        repeat (12) @(posedge clk);
        #1;
        check("ign_idle_after", 16'(busy), 16'h0);

        // Reset mid-operation aborts without a done pulse.
        a     = 8'h12;
        b     = 8'h34;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_product", product, 16'h0000);
        check("abort_busy", 16'(busy), 16'h0);
        check("abort_done", 16'(done), 16'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op(8'h12, 8'h34, 16'h03A8);
        repeat (2) @(posedge clk);
        #1;

        // start held high: one result every 9 cycles.
        a     = 8'h02;
        b     = 8'h03;
        start = 1'b1;
        for (int r = 0; r < 3; r++) exp_q.push_back(16'h0006);
        @(posedge clk);
        for (int r = 0; r < 3; r++) begin
            repeat (7) @(posedge clk);
            #1;
            check("b2b_done_early", 16'(done), 16'h0);
            @(posedge clk);
            #1;
            check("b2b_done", 16'(done), 16'h1);
            check("b2b_busy", 16'(busy), 16'h0);
            if (r == 2) start = 1'b0;
            @(posedge clk);
            #1;
            check("b2b_busy_reaccept", 16'(busy), (r == 2) ? 16'h0 : 16'h1);
        end

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
